riscv_decode_stage: RTL and testbench
=====================================

Name: riscv_decode_stage

Overview:
RV32I decode stage that sits directly upstream of riscV_alu and feeds it. It takes a fetched instruction, its PC and the register-file read data, and produces the 6-bit ALU operator code, both ALU operands, the branch immediate and the writeback controls. Results are held in a single pipeline register with a valid/ready handshake and a flush.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
X0_WE_SUPPRESS, 1, when 1, rd_we_o is forced to 0 if rd == 0.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_ni  in  1  asynchronous, active-low reset.
valid_i  in  1  instr_i, pc_i, rs1_data_i and rs2_data_i are valid.
ready_o  out  1  stage accepts input this cycle.
instr_i  in  32  instruction word.
pc_i  in  32  PC of instr_i.
rs1_addr_o  out  5  combinational: instr_i[19:15].
rs2_addr_o  out  5  combinational: instr_i[24:20].
rs1_data_i  in  32  register-file data for rs1_addr_o, same cycle.
rs2_data_i  in  32  register-file data for rs2_addr_o, same cycle.
flush_i  in  1  kill the held entry and any input in this cycle.
valid_o  out  1  registered outputs are valid.
ready_i  in  1  downstream accepts.
alu_op_o  out  6  operator code for the ALU.
operand_a_o  out  32  ALU operand A.
operand_b_o  out  32  ALU operand B.
imm_o  out  32  sign-extended B-immediate; 0 for non-branches.
pc_o  out  32  PC of the held instruction.
rd_addr_o  out  5  destination register.
rd_we_o  out  1  writeback enable.
branch_o  out  1  held instruction is a conditional branch.
illegal_o  out  1  held instruction is unsupported.

Behaviour:
- Reset (asynchronous, active-low):
  - valid_o=0, alu_op_o=6'b011000, branch_o=0, illegal_o=0, rd_we_o=0.
  - All other registered outputs are 0.
  - Reset mid-transfer drops the held entry; no output is valid on the first edge after release.
- Handshake:
  - ready_o = !valid_o | ready_i | flush_i.
  - Accept when valid_i & ready_o & !flush_i: decode and capture on the edge; valid_o=1 next cycle. Latency is 1 cycle.
  - valid_o & !ready_i: all outputs stay stable; ready_o=0.
  - Simultaneous drain and accept (valid_o & ready_i & valid_i): back-to-back transfer with no bubble.
  - valid_o & ready_i & !valid_i: valid_o=0 next cycle.
- Flush: flush_i=1 clears valid_o on the next edge and discards the input in that cycle. Flush has priority over accept and hold.
- Operator codes:
  - ADD 011000, SUB 011001, XOR 101111, OR 101110, AND 010101.
  - SRA 100100, SRL 100101, SLL 100111.
  - LTS 000000, LTU 000001, GES 001010, GEU 001011, EQ 001100, NE 001101.
- OP (0110011): a=rs1_data, b=rs2_data, we=1.
  - funct3 000: ADD (funct7 0000000) or SUB (funct7 0100000).
  - 001 SLL, 010 LTS, 011 LTU, 100 XOR, 110 OR, 111 AND.
  - 101: SRL (funct7 0000000) or SRA (funct7 0100000).
  - Any other funct7 is illegal.
- OP-IMM (0010011): a=rs1_data, b=sign-extended I-imm, we=1, same funct3 mapping, no SUB.
  - Shifts use b={27'b0,instr[24:20]}.
  - SLLI requires funct7=0. SRLI/SRAI select by funct7 0000000/0100000; any other funct7 is illegal.
- LUI (0110111): ADD, a=0, b={instr[31:12],12'b0}, we=1.
- AUIPC (0010111): ADD, a=pc_i, b=U-imm, we=1.
- BRANCH (1100011): a=rs1_data, b=rs2_data, we=0, branch_o=1, imm_o=B-imm.
  - funct3 000 EQ, 001 NE, 100 LTS, 101 GES, 110 LTU, 111 GEU.
  - funct3 010/011 are illegal.
- Any other opcode, or instr[1:0] != 2'b11: illegal_o=1, alu_op_o=ADD, we=0, branch_o=0, operands 0.
- Illegal entries still pass through the handshake normally.
- rd_addr_o = instr[11:7] for all formats. rd_we_o=0 when rd=0 if X0_WE_SUPPRESS=1.
- All adds and extensions are 32-bit, and no widths are truncated silently.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1_data=5, rs2_data=7 -> next cycle: valid_o=1, alu_op_o=011000, a=5, b=7, rd=3, rd_we_o=1; rs1_addr_o=1 and rs2_addr_o=2 combinationally.
- SRAI x5,x6,3 (0x40335293) then LUI x1,0x12345 (0x123450B7), back-to-back with ready_i=1 -> cycle 1: op=100100, b=3; cycle 2: op=011000, a=0, b=0x12345000; no bubble.
- BLT x1,x2,+8 (0x0020C463) -> op=000000, imm_o=8, branch_o=1, rd_we_o=0.
- Backpressure: ready_i=0 for 3 cycles while the next instruction waits -> ready_o=0, outputs unchanged; next instruction captured on the edge after ready_i=1.
- instr 0xFFFFFFFF -> illegal_o=1, rd_we_o=0; ADDI x0,x0,0 (0x00000013) -> rd_we_o=0.
- flush_i while valid_o=1 and valid_i=1 -> valid_o=0 next cycle, input dropped; rst_ni pulsed low mid-hold -> outputs return to reset values immediately.

Source files
------------

// File: rtl/riscv_decode_stage.sv
// RV32I decode stage: turns a fetched instruction plus register-file data into
// ALU operator/operands, branch immediate and writeback controls, held in one pipeline register.
module riscv_decode_stage #(
  parameter int XLEN           = 32,
  parameter bit X0_WE_SUPPRESS = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [5:0]      alu_op_o,
  output logic [XLEN-1:0] operand_a_o,
  output logic [XLEN-1:0] operand_b_o,
  output logic [XLEN-1:0] imm_o,
  output logic [XLEN-1:0] pc_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_we_o,
  output logic            branch_o,
  output logic            illegal_o
);

  localparam logic [5:0] OP_ADD = 6'b011000, OP_SUB = 6'b011001, OP_XOR = 6'b101111;
  localparam logic [5:0] OP_OR  = 6'b101110, OP_AND = 6'b010101, OP_SRA = 6'b100100;
  localparam logic [5:0] OP_SRL = 6'b100101, OP_SLL = 6'b100111, OP_LTS = 6'b000000;
  localparam logic [5:0] OP_LTU = 6'b000001, OP_GES = 6'b001010, OP_GEU = 6'b001011;
  localparam logic [5:0] OP_EQ  = 6'b001100, OP_NE  = 6'b001101;

  localparam logic [6:0] OPC_OP = 7'b0110011, OPC_OP_IMM = 7'b0010011, OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111, OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_ZERO = 7'b0000000, F7_ALT = 7'b0100000;

  typedef struct packed {
    logic [5:0]      alu_op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic            we;
    logic            branch;
    logic            illegal;
  } entry_t;

  localparam entry_t RESET_ENTRY = '{OP_ADD, '0, '0, '0, '0, 5'd0, 1'b0, 1'b0, 1'b0};

  // funct3 -> operator for OP/OP-IMM; SUB/SRA are resolved from funct7 by the caller.
  function automatic logic [5:0] alu_base(input logic [2:0] f3);
    case (f3)
      3'b000:  alu_base = OP_ADD;
      3'b001:  alu_base = OP_SLL;
      3'b010:  alu_base = OP_LTS;
      3'b011:  alu_base = OP_LTU;
      3'b100:  alu_base = OP_XOR;
      3'b101:  alu_base = OP_SRL;
      3'b110:  alu_base = OP_OR;
      default: alu_base = OP_AND;
    endcase
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] i_imm, u_imm, b_imm, shamt;
  entry_t          dec;
  logic            bad;

  assign opcode     = instr_i[6:0];
  assign funct3     = instr_i[14:12];
  assign funct7     = instr_i[31:25];
  assign rs1_addr_o = instr_i[19:15];
  assign rs2_addr_o = instr_i[24:20];
  assign i_imm      = {{20{instr_i[31]}}, instr_i[31:20]};
  assign u_imm      = {instr_i[31:12], 12'b0};
  assign b_imm      = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign shamt      = {27'b0, instr_i[24:20]};

  always_comb begin
    dec        = RESET_ENTRY;
    dec.pc     = pc_i;
    dec.rd     = instr_i[11:7];
    bad        = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.a      = rs1_data_i;
        dec.b      = rs2_data_i;
        dec.we     = 1'b1;
        dec.alu_op = alu_base(funct3);
        if (funct7 == F7_ALT && funct3 == 3'b000) dec.alu_op = OP_SUB;
        if (funct7 == F7_ALT && funct3 == 3'b101) dec.alu_op = OP_SRA;
        bad = !(funct7 == F7_ZERO ||
                (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        dec.a      = rs1_data_i;
        dec.b      = i_imm;
        dec.we     = 1'b1;
        dec.alu_op = alu_base(funct3);
        // Shifts reuse the upper immediate bits as funct7.
        if (funct3 == 3'b001 || funct3 == 3'b101) dec.b = shamt;
        if (funct7 == F7_ALT && funct3 == 3'b101) dec.alu_op = OP_SRA;
        bad = (funct3 == 3'b001 && funct7 != F7_ZERO) ||
              (funct3 == 3'b101 && funct7 != F7_ZERO && funct7 != F7_ALT);
      end
      OPC_LUI: begin
        dec.b  = u_imm;
        dec.we = 1'b1;
      end
      OPC_AUIPC: begin
        dec.a  = pc_i;
        dec.b  = u_imm;
        dec.we = 1'b1;
      end
      OPC_BRANCH: begin
        dec.a      = rs1_data_i;
        dec.b      = rs2_data_i;
        dec.imm    = b_imm;
        dec.branch = 1'b1;
        case (funct3)
          3'b000:  dec.alu_op = OP_EQ;
          3'b001:  dec.alu_op = OP_NE;
          3'b100:  dec.alu_op = OP_LTS;
          3'b101:  dec.alu_op = OP_GES;
          3'b110:  dec.alu_op = OP_LTU;
          3'b111:  dec.alu_op = OP_GEU;
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec.alu_op  = OP_ADD;
      dec.a       = '0;
      dec.b       = '0;
      dec.imm     = '0;
      dec.we      = 1'b0;
      dec.branch  = 1'b0;
      dec.illegal = 1'b1;
    end
    if (X0_WE_SUPPRESS && dec.rd == 5'd0) dec.we = 1'b0;
  end

  // Handshake: a transfer happens on an edge where valid and ready are both high.
  // Input side accepts when the register is empty, being drained, or flushed;
  // flush discards both the held entry and this cycle's input.
  entry_t entry_q, entry_d;
  logic   valid_q, valid_d;
  logic   accept;

  assign ready_o = !valid_q | ready_i | flush_i;
  assign accept  = valid_i & ready_o & !flush_i;

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      entry_d = dec;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      entry_q <= RESET_ENTRY;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign valid_o     = valid_q;
  assign alu_op_o    = entry_q.alu_op;
  assign operand_a_o = entry_q.a;
  assign operand_b_o = entry_q.b;
  assign imm_o       = entry_q.imm;
  assign pc_o        = entry_q.pc;
  assign rd_addr_o   = entry_q.rd;
  assign rd_we_o     = entry_q.we;
  assign branch_o    = entry_q.branch;
  assign illegal_o   = entry_q.illegal;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Bench for riscv_decode_stage: directed scenarios plus a randomized stream
// checked against an instruction-level reference model and a one-deep expected queue.
module tb_riscv_decode_stage;

  localparam int W = 142;
  localparam logic [5:0] ADD = 6'b011000, SUB = 6'b011001, SRA = 6'b100100;
  localparam logic [W-1:0] RST_VEC = {ADD, 136'b0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, ready_o, flush_i, valid_o, ready_i;
  logic [31:0] instr_i, pc_i, rs1_data_i, rs2_data_i;
  logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic [5:0]  alu_op_o;
  logic [31:0] operand_a_o, operand_b_o, imm_o, pc_o;
  logic        rd_we_o, branch_o, illegal_o;
  logic [W-1:0] obs;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [W-1:0] exp_q[$];

  logic [5:0] alu_tab[8] = '{6'b011000, 6'b100111, 6'b000000, 6'b000001,
                             6'b101111, 6'b100101, 6'b101110, 6'b010101};
  logic [5:0] br_tab[8]  = '{6'b001100, 6'b001101, 6'b000000, 6'b000000,
                             6'b000000, 6'b001010, 6'b000001, 6'b001011};

  always #5 clk = ~clk;

  riscv_decode_stage dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .flush_i(flush_i),
    .valid_o(valid_o), .ready_i(ready_i), .alu_op_o(alu_op_o),
    .operand_a_o(operand_a_o), .operand_b_o(operand_b_o), .imm_o(imm_o),
    .pc_o(pc_o), .rd_addr_o(rd_addr_o), .rd_we_o(rd_we_o),
    .branch_o(branch_o), .illegal_o(illegal_o)
  );

  assign obs = {alu_op_o, operand_a_o, operand_b_o, imm_o, pc_o, rd_addr_o,
                rd_we_o, branch_o, illegal_o};

  // Instruction-level reference: what the held entry must look like.
  function automatic logic [W-1:0] model(input logic [31:0] ins, pc, r1, r2);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    logic [5:0] op;
    logic [31:0] a, b, imm;
    logic we, br, ill;
    logic signed [11:0] iimm;
    logic signed [12:0] bimm;
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25]; rd = ins[11:7];
    op = ADD; a = 0; b = 0; imm = 0; we = 0; br = 0; ill = 0;
    if (opc == 7'b0110011) begin
      a = r1; b = r2; we = 1; op = alu_tab[f3];
      if (f7 == 7'h20 && f3 == 3'd0) op = SUB;
      else if (f7 == 7'h20 && f3 == 3'd5) op = SRA;
      else if (f7 != 7'h00) ill = 1;
    end else if (opc == 7'b0010011) begin
      a = r1; iimm = ins[31:20]; b = 32'(iimm); we = 1; op = alu_tab[f3];
      if (f3 == 3'd1 || f3 == 3'd5) begin
        b = 32'(ins[24:20]);
        if (f3 == 3'd5 && f7 == 7'h20) op = SRA;
        else if (f7 != 7'h00) ill = 1;
      end
    end else if (opc == 7'b0110111) begin
      b = ins & 32'hFFFF_F000; we = 1;
    end else if (opc == 7'b0010111) begin
      a = pc; b = ins & 32'hFFFF_F000; we = 1;
    end else if (opc == 7'b1100011) begin
      a = r1; b = r2; br = 1; op = br_tab[f3];
      bimm = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      imm = 32'(bimm);
      if (f3 == 3'd2 || f3 == 3'd3) ill = 1;
    end else begin
      ill = 1;
    end
    if (ill) begin op = ADD; a = 0; b = 0; imm = 0; we = 0; br = 0; end
    if (rd == 5'd0) we = 0;
    return {op, a, b, imm, pc, rd, we, br, ill};
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r, s;
    logic [6:0] f7;
    r = $urandom; s = $urandom;
    case (s[1:0])
      2'd0: f7 = 7'h00;
      2'd1: f7 = 7'h20;
      default: f7 = r[31:25];
    endcase
    case ($urandom_range(0, 6))
      0: return r;
      1: return {f7, r[24:7], 7'b0110011};
      2: return {f7, r[24:7], 7'b0010011};
      3: return {r[31:7], 7'b0110111};
      4: return {r[31:7], 7'b0010111};
      5: return {r[31:7], 7'b1100011};
      default: return {r[31:12], 5'd0, r[6:2], 2'b11};
    endcase
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, pc, r1, r2);
    valid_i = v; instr_i = ins; pc_i = pc; rs1_data_i = r1; rs2_data_i = r2;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_i = 0; ready_i = 1; flush_i = 0;
    instr_i = 0; pc_i = 0; rs1_data_i = 0; rs2_data_i = 0;
    step(); step();
    rst_n = 1'b1;
    #1;
    total_cnt++;
    if (obs !== RST_VEC || valid_o !== 1'b0 || ready_o !== 1'b1) $display("FAIL reset: got %h v=%b r=%b expected %h v=0 r=1", obs, valid_o, ready_o, RST_VEC);
    else pass_cnt++;
  endtask

  task automatic test_add();
    logic [W-1:0] e;
    e = model(32'h002081B3, 32'h100, 5, 7);
    drive(1, 32'h002081B3, 32'h100, 5, 7);
    total_cnt++;
    if (rs1_addr_o !== 5'd1 || rs2_addr_o !== 5'd2) $display("FAIL add_raddr: got %0d,%0d expected 1,2", rs1_addr_o, rs2_addr_o);
    else pass_cnt++;
    step(); drive(0, 0, 0, 0, 0);
    total_cnt++;
    if (valid_o !== 1'b1 || alu_op_o !== ADD || operand_a_o !== 32'd5 || operand_b_o !== 32'd7 ||
        rd_addr_o !== 5'd3 || rd_we_o !== 1'b1 || obs !== e)
      $display("FAIL add: got v=%b %h expected v=1 %h", valid_o, obs, e);
    else pass_cnt++;
    step();
    total_cnt++;
    if (valid_o !== 1'b0) $display("FAIL add_drain: got valid_o=%b expected 0", valid_o);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e1, e2;
    ready_i = 1;
    e1 = model(32'h40335293, 32'h200, 32'h8000_0000, 0);
    e2 = model(32'h123450B7, 32'h204, 32'h1, 32'h2);
    drive(1, 32'h40335293, 32'h200, 32'h8000_0000, 0);
    step(); drive(1, 32'h123450B7, 32'h204, 32'h1, 32'h2);
    total_cnt++;
    if (valid_o !== 1'b1 || alu_op_o !== SRA || operand_b_o !== 32'd3 || obs !== e1)
      $display("FAIL b2b_srai: got v=%b %h expected v=1 %h", valid_o, obs, e1);
    else pass_cnt++;
    step(); drive(0, 0, 0, 0, 0);
    total_cnt++;
    if (valid_o !== 1'b1 || alu_op_o !== ADD || operand_a_o !== 32'd0 ||
        operand_b_o !== 32'h1234_5000 || obs !== e2)
      $display("FAIL b2b_lui: got v=%b %h expected v=1 %h", valid_o, obs, e2);
    else pass_cnt++;
    step();
  endtask

  task automatic test_branch();
    logic [W-1:0] e;
    e = model(32'h0020C463, 32'h300, 1, 2);
    drive(1, 32'h0020C463, 32'h300, 1, 2);
    step(); drive(0, 0, 0, 0, 0);
    total_cnt++;
    if (alu_op_o !== 6'b000000 || imm_o !== 32'd8 || branch_o !== 1'b1 || rd_we_o !== 1'b0 || obs !== e)
      $display("FAIL blt: got %h expected %h", obs, e);
    else pass_cnt++;
    step();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] ea, eb;
    ea = model(32'h002081B3, 32'h400, 11, 22);
    eb = model(32'h0020C233, 32'h404, 33, 44);
    ready_i = 1;
    drive(1, 32'h002081B3, 32'h400, 11, 22);
    step();
    ready_i = 0;
    drive(1, 32'h0020C233, 32'h404, 33, 44);
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (ready_o !== 1'b0 || valid_o !== 1'b1 || obs !== ea)
        $display("FAIL bp_hold%0d: got r=%b v=%b %h expected r=0 v=1 %h", i, ready_o, valid_o, obs, ea);
      else pass_cnt++;
      step();
    end
    ready_i = 1; #1;
    total_cnt++;
    if (ready_o !== 1'b1 || obs !== ea) $display("FAIL bp_release: got r=%b %h expected r=1 %h", ready_o, obs, ea);
    else pass_cnt++;
    step(); drive(0, 0, 0, 0, 0);
    total_cnt++;
    if (valid_o !== 1'b1 || obs !== eb) $display("FAIL bp_next: got v=%b %h expected v=1 %h", valid_o, obs, eb);
    else pass_cnt++;
    step();
  endtask

  task automatic test_illegal();
    logic [W-1:0] e1, e2;
    e1 = model(32'hFFFF_FFFF, 32'h500, 9, 9);
    e2 = model(32'h0000_0013, 32'h504, 9, 9);
    drive(1, 32'hFFFF_FFFF, 32'h500, 9, 9);
    step(); drive(1, 32'h0000_0013, 32'h504, 9, 9);
    total_cnt++;
    if (illegal_o !== 1'b1 || rd_we_o !== 1'b0 || valid_o !== 1'b1 || obs !== e1)
      $display("FAIL illegal: got %h expected %h", obs, e1);
    else pass_cnt++;
    step(); drive(0, 0, 0, 0, 0);
    total_cnt++;
    if (illegal_o !== 1'b0 || rd_we_o !== 1'b0 || obs !== e2)
      $display("FAIL addi_x0: got %h expected %h", obs, e2);
    else pass_cnt++;
    step();
  endtask

  task automatic test_flush();
    drive(1, 32'h002081B3, 32'h600, 1, 1);
    step();
    ready_i = 0; flush_i = 1;
    drive(1, 32'h0020C233, 32'h604, 2, 2);
    total_cnt++;
    if (ready_o !== 1'b1 || valid_o !== 1'b1) $display("FAIL flush_ready: got r=%b v=%b expected r=1 v=1", ready_o, valid_o);
    else pass_cnt++;
    step();
    flush_i = 0; ready_i = 1;
    drive(0, 0, 0, 0, 0);
    total_cnt++;
    if (valid_o !== 1'b0) $display("FAIL flush_clear: got valid_o=%b expected 0", valid_o);
    else pass_cnt++;
    step();
    total_cnt++;
    if (valid_o !== 1'b0) $display("FAIL flush_drop: got valid_o=%b expected 0", valid_o);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] e;
    e = model(32'h002081B3, 32'h700, 3, 4);
    drive(1, 32'h002081B3, 32'h700, 3, 4);
    step();
    ready_i = 0;
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0; #1;
    total_cnt++;
    if (obs !== RST_VEC || valid_o !== 1'b0) $display("FAIL reset_mid: got v=%b %h expected v=0 %h", valid_o, obs, RST_VEC);
    else pass_cnt++;
    step();
    rst_n = 1'b1; ready_i = 1;
    drive(1, 32'h002081B3, 32'h700, 3, 4);
    step(); drive(0, 0, 0, 0, 0);
    total_cnt++;
    if (valid_o !== 1'b1 || obs !== e) $display("FAIL reset_recover: got v=%b %h expected v=1 %h", valid_o, obs, e);
    else pass_cnt++;
    step();
  endtask

  task automatic test_random();
    logic [W-1:0] e;
    logic v, r, f;
    logic [31:0] ins, pc, r1, r2;
    exp_q.delete();
    for (int i = 0; i < 500; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 15) == 0);
      ins = gen_instr(); pc = $urandom & 32'hFFFF_FFFC; r1 = $urandom; r2 = $urandom;
      ready_i = r; flush_i = f;
      drive(v, ins, pc, r1, r2);
      total_cnt++;
      if (valid_o !== (exp_q.size() != 0) || ready_o !== (exp_q.size() == 0 || r || f))
        $display("FAIL rand_hs%0d: got v=%b r=%b expected v=%b", i, valid_o, ready_o, exp_q.size() != 0);
      else pass_cnt++;
      if (f) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else begin
        if (exp_q.size() != 0 && r) begin
          e = exp_q.pop_front();
          total_cnt++;
          if (obs !== e) $display("FAIL rand_data%0d: got %h expected %h", i, obs, e);
          else pass_cnt++;
        end
        if (v && exp_q.size() == 0) exp_q.push_back(model(ins, pc, r1, r2));
      end
      step();
    end
    flush_i = 0; ready_i = 1;
    drive(0, 0, 0, 0, 0);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (valid_o !== 1'b1 || obs !== e) $display("FAIL rand_tail: got v=%b %h expected v=1 %h", valid_o, obs, e);
      else pass_cnt++;
    end
    step();
    total_cnt++;
    if (valid_o !== 1'b0) $display("FAIL rand_empty: got valid_o=%b expected 0", valid_o);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_branch();
    test_backpressure();
    test_illegal();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
